// File: rtl/single_port_block_ram.sv
`default_nettype none
// ============================================================================
// Module   : single_port_block_ram
// Purpose  : Single-port synchronous RAM with a per-byte write mask and a
//            registered write-first read port. Define BLOCKRAM_OUTPUT_REG_EN
//            to add a second output register, which gives 2-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module single_port_block_ram #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / 8
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]            write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out
);

    localparam int c_byte_len   = 8;
    localparam int c_full_depth = 2 ** SET_PTR_WIDTH_IN_BITS;

    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] r_mem [NUM_SET];
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] r_read_entry;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] w_stored_entry;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] w_merged_entry;
    logic                                 w_addr_valid;

    // Only a non-power-of-two depth can see an address past the last entry.
    generate
        if (NUM_SET == c_full_depth) begin : g_full_depth
            assign w_addr_valid = 1'b1;
        end else begin : g_partial_depth
            localparam logic [SET_PTR_WIDTH_IN_BITS:0] c_num_set_ext =
                NUM_SET[SET_PTR_WIDTH_IN_BITS:0];
            assign w_addr_valid = ({1'b0, access_set_addr_in} < c_num_set_ext);
        end
    endgenerate

    assign w_stored_entry = w_addr_valid ? r_mem[access_set_addr_in] : '0;

    // Entry as it will look once this cycle's masked write lands.
    always_comb begin
        w_merged_entry = w_stored_entry;
        for (int i = 0; i < WRITE_MASK_LEN; i++) begin
            if (write_en_in[i]) begin
                w_merged_entry[i*c_byte_len +: c_byte_len] =
                    write_entry_in[i*c_byte_len +: c_byte_len];
            end
        end
        if (!w_addr_valid) begin
            w_merged_entry = '0;
        end
    end

    // Array has no reset so it maps onto a plain RAM macro; reset only blocks writes.
    always_ff @(posedge clk_in) begin
        if (!reset_in && access_en_in && w_addr_valid) begin
            for (int i = 0; i < WRITE_MASK_LEN; i++) begin
                if (write_en_in[i]) begin
                    r_mem[access_set_addr_in][i*c_byte_len +: c_byte_len] <=
                        write_entry_in[i*c_byte_len +: c_byte_len];
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_read_entry <= '0;
        end else if (access_en_in) begin
            r_read_entry <= w_merged_entry;
        end
    end

`ifdef BLOCKRAM_OUTPUT_REG_EN
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] r_read_entry_d2;
    logic                                 r_access_en_d1;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_access_en_d1  <= 1'b0;
            r_read_entry_d2 <= '0;
        end else begin
            r_access_en_d1 <= access_en_in;
            if (r_access_en_d1) begin
                r_read_entry_d2 <= r_read_entry;
            end
        end
    end

    assign read_entry_out = r_read_entry_d2;
`else
    assign read_entry_out = r_read_entry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_single_port_block_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_single_port_block_ram
// Purpose  : Directed plus random checks of single_port_block_ram against a
//            reference memory model with an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_single_port_block_ram;

    localparam int c_w     = 64;
    localparam int c_sets  = 64;
    localparam int c_aw    = 6;
    localparam int c_mask  = 8;

    logic             clk_in = 1'b0;
    logic             reset_in = 1'b0;
    logic             access_en_in = 1'b0;
    logic [c_mask-1:0] write_en_in = '0;
    logic [c_aw-1:0]  access_set_addr_in = '0;
    logic [c_w-1:0]   write_entry_in = '0;
    logic [c_w-1:0]   read_entry_out;

    typedef struct {
        string          tag;
        logic [c_w-1:0] val;
    } exp_t;

    exp_t           sb[$];
    logic [c_w-1:0] model [c_sets];
    logic [c_w-1:0] exp_out = '0;
    int             n_vec = 0;
    int             n_err = 0;

    single_port_block_ram #(
        .SINGLE_ENTRY_SIZE_IN_BITS(c_w),
        .NUM_SET(c_sets),
        .SET_PTR_WIDTH_IN_BITS(c_aw),
        .WRITE_MASK_LEN(c_mask)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .access_en_in(access_en_in),
        .write_en_in(write_en_in),
        .access_set_addr_in(access_set_addr_in),
        .write_entry_in(write_entry_in),
        .read_entry_out(read_entry_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [c_w-1:0] obs,
                         input logic [c_w-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called with clk_in low; returns with clk_in low after the next falling edge.
    task automatic step(input logic en, input logic [c_mask-1:0] we,
                        input logic [c_aw-1:0] a, input logic [c_w-1:0] d,
                        input string tag);
        exp_t e;
        access_en_in       = en;
        write_en_in        = we;
        access_set_addr_in = a;
        write_entry_in     = d;
        if (en) begin
            for (int i = 0; i < c_mask; i++) begin
                if (we[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
            end
            exp_out = model[a];
        end
        e.tag = tag;
        e.val = exp_out;
        sb.push_back(e);
        @(posedge clk_in);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, observed %h required an entry", tag, read_entry_out);
        end else begin
            e = sb.pop_front();
            check(e.tag, read_entry_out, e.val);
        end
        @(negedge clk_in);
    endtask

    initial begin
        logic [c_mask-1:0] rmask;
        logic [c_aw-1:0]   raddr;
        logic [c_w-1:0]    rdata;

        #1 reset_in = 1'b1;
        #1 check("reset_initial", read_entry_out, '0);
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;

        step(1'b1, 8'hFF, 6'd63, 64'hFFFFFFFF_00000000, "full_write");
        step(1'b1, 8'h00, 6'd63, 64'h00000000_FFFFFFFF, "read_no_write");
        step(1'b1, 8'hFF, 6'd62, 64'h0, "zero_write_a");
        step(1'b1, 8'hFF, 6'd62, 64'h0, "zero_write_b");
        step(1'b1, 8'b11001100, 6'd62, {c_w{1'b1}}, "byte_mask");
        check("byte_mask_const", exp_out, 64'hFFFF0000_FFFF0000);

        // Write launched, then reset rises mid-cycle before its edge.
        access_en_in       = 1'b1;
        write_en_in        = 8'hFF;
        access_set_addr_in = 6'd63;
        write_entry_in     = 64'hDEADBEEF_CAFEF00D;
        #2 reset_in = 1'b1;
        #1 check("reset_async", read_entry_out, '0);
        @(posedge clk_in);
        #1 check("reset_hold", read_entry_out, '0);
        @(negedge clk_in);
        reset_in = 1'b0;
        exp_out  = '0;
        step(1'b1, 8'h00, 6'd63, 64'h0, "post_reset_read63");

        step(1'b1, 8'h00, 6'd62, 64'h0, "read62");
        step(1'b0, 8'hFF, 6'd63, 64'h12345678_9ABCDEF0, "disable_hold");
        step(1'b0, 8'h00, 6'd1, 64'h0, "disable_hold2");
        step(1'b1, 8'h00, 6'd63, 64'h0, "read63_unchanged");

        step(1'b1, 8'hFF, 6'd5, 64'h0, "init5");
        step(1'b1, 8'h0F, 6'd5, 64'h11111111_11111111, "acc_low");
        step(1'b1, 8'hF0, 6'd5, 64'h22222222_22222222, "acc_high");
        step(1'b1, 8'h00, 6'd5, 64'h0, "acc_read");
        check("acc_const", exp_out, 64'h22222222_11111111);

        for (int a = 0; a < 8; a++) begin
            step(1'b1, 8'hFF, c_aw'(a), {$urandom, $urandom}, "rand_init");
        end
        for (int n = 0; n < 40; n++) begin
            rmask = 8'($urandom);
            if (n % 3 == 0) rmask = 8'h00;
            raddr = c_aw'($urandom_range(0, 7));
            rdata = {$urandom, $urandom};
            step(($urandom_range(0, 4) != 0), rmask, raddr, rdata, "rand_op");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed hang required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
